// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : conv_layer_scheduler
//  Purpose  : Runs one conv2d engine over NUM_LAYERS back-to-back layers.
//             For each layer it drives the engine start/done handshake and
//             supplies the weight/bias base offsets. It also flips the
//             ping-pong activation bank between layers. A watchdog and an
//             abort path return the block to IDLE without an all_done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    run          in   single-cycle run request (accepted only in IDLE)
//    abort        in   level, cancels an active run
//    busy         out  high in every state except IDLE
//    all_done     out  one-cycle pulse when the last layer completes
//    error        out  sticky watchdog flag, cleared by rst or accepted run
//    cur_layer    out  index of layer being processed
//    buf_sel      out  activation bank the engine reads (writes !buf_sel)
//    weight_base  out  cur_layer * WEIGHT_STRIDE
//    bias_base    out  cur_layer * BIAS_STRIDE
//    conv_start   out  engine start, level held until done
//    conv_done    in   engine done, level held while start is high
//    run_cycles   out  busy-cycle count of the latest run
//                      (only when CONV_SCHED_PERF_EN is defined)
//  Optional build macro: CONV_SCHED_PERF_EN
// ============================================================================
module conv_layer_scheduler #(
    parameter int NUM_LAYERS     = 4,
    parameter int LAYER_W        = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int WEIGHT_STRIDE  = 8,
    parameter int BIAS_STRIDE    = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  abort,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error,
    output logic [LAYER_W-1:0]    cur_layer,
    output logic                  buf_sel,
    output logic [ADDR_WIDTH-1:0] weight_base,
    output logic [ADDR_WIDTH-1:0] bias_base,
    output logic                  conv_start,
    input  logic                  conv_done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]           run_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_ADVANCE = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    localparam logic [LAYER_W-1:0] c_last_layer = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]    c_wd_limit   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]    c_wd_max     = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_busy;
    logic                    r_all_done;
    logic                    r_error;
    logic [LAYER_W-1:0]      r_layer;
    logic                    r_buf_sel;
    logic [ADDR_WIDTH-1:0]   r_weight_base;
    logic [ADDR_WIDTH-1:0]   r_bias_base;
    logic                    r_conv_start;
    logic [TO_W-1:0]         r_wd;

    logic                    w_all_done_nxt;
    logic                    w_error_nxt;
    logic [LAYER_W-1:0]      w_layer_nxt;
    logic                    w_buf_sel_nxt;
    logic                    w_start_nxt;
    logic [TO_W-1:0]         w_wd_nxt;
    logic                    w_run_accept;
    logic                    w_abortable;

    // Abort only has effect while the engine may be running or about to run;
    // IDLE ignores it and DRAIN is already heading home.
    assign w_abortable = (r_state == S_LAUNCH) || (r_state == S_WAIT) ||
                         (r_state == S_RELEASE) || (r_state == S_ADVANCE);

    always_comb begin
        w_state_nxt    = r_state;
        w_all_done_nxt = 1'b0;
        w_error_nxt    = r_error;
        w_layer_nxt    = r_layer;
        w_buf_sel_nxt  = r_buf_sel;
        w_start_nxt    = r_conv_start;
        w_wd_nxt       = r_wd;
        w_run_accept   = 1'b0;

        if (w_abortable && abort) begin
            // Abort outranks done and timeout; error is left untouched.
            w_start_nxt = 1'b0;
            w_state_nxt = S_DRAIN;
            if (r_state == S_LAUNCH) begin
                w_wd_nxt = '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        w_run_accept  = 1'b1;
                        w_layer_nxt   = '0;
                        w_buf_sel_nxt = 1'b0;
                        w_error_nxt   = 1'b0;
                        w_state_nxt   = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    w_start_nxt = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        w_start_nxt = 1'b0;
                        w_state_nxt = S_RELEASE;
                    end else if (r_wd == c_wd_limit) begin
                        w_start_nxt = 1'b0;
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end else if (r_wd != c_wd_max) begin
                        w_wd_nxt = r_wd + TO_W'(1);
                    end
                end
                S_RELEASE: begin
                    // Engine must drop done before the next start can be issued.
                    if (!conv_done) begin
                        w_state_nxt = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (r_layer == c_last_layer) begin
                        w_all_done_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_layer_nxt   = r_layer + LAYER_W'(1);
                        w_buf_sel_nxt = ~r_buf_sel;
                        w_state_nxt   = S_LAUNCH;
                    end
                end
                S_DRAIN: begin
                    if (!conv_done) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_all_done    <= 1'b0;
            r_error       <= 1'b0;
            r_layer       <= '0;
            r_buf_sel     <= 1'b0;
            r_weight_base <= '0;
            r_bias_base   <= '0;
            r_conv_start  <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_all_done    <= w_all_done_nxt;
            r_error       <= w_error_nxt;
            r_layer       <= w_layer_nxt;
            r_buf_sel     <= w_buf_sel_nxt;
            // Offsets are derived from the next layer index so they change
            // on the same edge as cur_layer.
            r_weight_base <= ADDR_WIDTH'(w_layer_nxt) * ADDR_WIDTH'(WEIGHT_STRIDE);
            r_bias_base   <= ADDR_WIDTH'(w_layer_nxt) * ADDR_WIDTH'(BIAS_STRIDE);
            r_conv_start  <= w_start_nxt;
            r_wd          <= w_wd_nxt;
        end
    end

    assign busy        = r_busy;
    assign all_done    = r_all_done;
    assign error       = r_error;
    assign cur_layer   = r_layer;
    assign buf_sel     = r_buf_sel;
    assign weight_base = r_weight_base;
    assign bias_base   = r_bias_base;
    assign conv_start  = r_conv_start;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] r_run_cycles;

    // Counts every cycle busy is high; stops by itself once busy falls and
    // keeps the total until the next accepted run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cycles <= '0;
        end else if (w_run_accept) begin
            r_run_cycles <= '0;
        end else if (r_busy) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign run_cycles = r_run_cycles;
`endif

endmodule

`default_nettype wire

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences the conv2d engine across NUM_LAYERS back-to-back layers. Per layer it drives the engine's start/done handshake, supplies per-layer weight/bias base offsets and flips the ping-pong activation bank.
- Includes a watchdog and an abort path.
- Sits between the top-level controller (run/abort) and one conv2d instance plus its bank-switched memories.

Parameters:
- NUM_LAYERS, 4, number of layers per run (>=1)
- LAYER_W, 4, width of cur_layer; must satisfy 2^LAYER_W >= NUM_LAYERS
- ADDR_WIDTH, 16, width of base-offset outputs
- WEIGHT_STRIDE, 8, weight words per layer; weight_base = layer*WEIGHT_STRIDE
- BIAS_STRIDE, 1, bias words per layer; bias_base = layer*BIAS_STRIDE
- TIMEOUT_CYCLES, 1024, max cycles waiting for conv_done before error
- TO_W, 16, watchdog counter width

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- run, in, 1, single-cycle request to start a run; ignored unless IDLE
- abort, in, 1, level; cancels an active run
- busy, out, 1, high in every state except IDLE
- all_done, out, 1, one-cycle pulse when the last layer completes
- error, out, 1, sticky watchdog flag; cleared by rst or next accepted run
- cur_layer, out, LAYER_W, index of layer being processed
- buf_sel, out, 1, activation bank the engine reads; engine writes !buf_sel
- weight_base, out, ADDR_WIDTH, weight offset for cur_layer
- bias_base, out, ADDR_WIDTH, bias offset for cur_layer
- conv_start, out, 1, engine start (level, held until done)
- conv_done, in, 1, engine done (level, held while start high)

Behaviour:
- Reset values: state IDLE; busy=0, all_done=0, error=0, cur_layer=0, buf_sel=0, conv_start=0, weight_base=0, bias_base=0, watchdog=0.
- All outputs are registered. weight_base and bias_base update in the same cycle as cur_layer.
- States:
  - IDLE: on run=1, go to LAUNCH; set cur_layer=0, buf_sel=0, error=0.
  - LAUNCH: set conv_start=1, clear watchdog, go to WAIT_DONE.
  - WAIT_DONE: conv_start held at 1; watchdog increments each cycle.
    - conv_done=1: set conv_start=0, go to RELEASE.
    - watchdog==TIMEOUT_CYCLES-1 without done: set conv_start=0, error=1, go to DRAIN.
  - RELEASE: wait until conv_done=0 (engine has returned to idle), then go to ADVANCE.
  - ADVANCE:
    - cur_layer==NUM_LAYERS-1: pulse all_done, go to IDLE.
    - otherwise: cur_layer+1, buf_sel toggles, go to LAUNCH.
  - DRAIN: wait until conv_done=0, then go to IDLE. all_done is not pulsed.
- Latency, engine done to next conv_start: done seen (cycle N, start drops at N+1) → done low observed → ADVANCE (1 cycle) → LAUNCH (1 cycle) → conv_start=1. This gives a minimum of 3 cycles of start-low gap between layers.
- abort=1 in LAUNCH, WAIT_DONE, RELEASE or ADVANCE: next cycle conv_start=0, go to DRAIN. error is not set; cur_layer and buf_sel hold.
- Simultaneous events:
  - abort and conv_done in the same cycle: abort wins.
  - abort and timeout in the same cycle: abort wins, error stays 0.
- run while busy: ignored, no queuing.
- conv_done=1 while in IDLE or LAUNCH: ignored.
- Watchdog saturates and never wraps. It is cleared in LAUNCH.
- Reset mid-run: every output returns to its reset value on the next edge. conv_start drops, so the engine falls back to idle.
- NUM_LAYERS=1: buf_sel never toggles. all_done fires after the first layer.

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- When defined, add port run_cycles (out, 32): a counter cleared when run is accepted and incremented every cycle while busy=1. It freezes when the run leaves busy, whether by all_done, abort or error, and holds until the next accepted run. Reset value 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- NUM_LAYERS=3, engine model raises done 20 cycles after start and drops it 1 cycle after start falls; pulse run:
  - conv_start asserts 3 times; cur_layer goes 0,1,2; buf_sel goes 0,1,0.
  - weight_base goes 0,8,16; bias_base goes 0,1,2.
  - one all_done pulse; busy falls the same cycle.
- Engine never asserts done, TIMEOUT_CYCLES=16:
  - conv_start drops exactly 16 cycles after rising; error=1; no all_done; busy=0 after DRAIN.
  - next run clears error.
- Abort asserted 5 cycles into layer 1:
  - conv_start=0 next cycle; cur_layer stays 1; error=0; no all_done; returns to IDLE once done=0.
- Second run pulse while busy in layer 0, and done asserted while IDLE:
  - both ignored; the sequence is identical to the first scenario.
- rst asserted during WAIT_DONE of layer 2:
  - next edge: all outputs are at reset values (conv_start=0, cur_layer=0, buf_sel=0, busy=0).
- With CONV_SCHED_PERF_EN, first scenario:
  - run_cycles equals the exact busy-cycle count and holds after all_done until the next run.
